// File: rtl/rf_access_arbiter_if.sv
// Bus bundle for rf_access_arbiter.
//   Requester side : REQ_x, REQ_WR_x, REQ_ADDR_x, REQ_WDATA_x in;
//                    GNT_x, RDATA_x, RDATA_VLD_x, RD_ERR_x out.
//   Register file  : WrEN, RdEN, Address, WrData out;
//                    RdData, RdData_Valid in.
// Modports:
//   slave  - the arbiter. It accepts requests and drives the register file.
//   master - the environment: both requesters and the register file.
interface rf_access_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4
);
    logic                  REQ_0;
    logic                  REQ_1;
    logic                  REQ_WR_0;
    logic                  REQ_WR_1;
    logic [ADDR_WIDTH-1:0] REQ_ADDR_0;
    logic [ADDR_WIDTH-1:0] REQ_ADDR_1;
    logic [DATA_WIDTH-1:0] REQ_WDATA_0;
    logic [DATA_WIDTH-1:0] REQ_WDATA_1;
    logic                  GNT_0;
    logic                  GNT_1;
    logic [DATA_WIDTH-1:0] RDATA_0;
    logic [DATA_WIDTH-1:0] RDATA_1;
    logic                  RDATA_VLD_0;
    logic                  RDATA_VLD_1;
    logic                  RD_ERR_0;
    logic                  RD_ERR_1;
    logic                  WrEN;
    logic                  RdEN;
    logic [ADDR_WIDTH-1:0] Address;
    logic [DATA_WIDTH-1:0] WrData;
    logic [DATA_WIDTH-1:0] RdData;
    logic                  RdData_Valid;

    modport slave (
        input  REQ_0, REQ_1, REQ_WR_0, REQ_WR_1, REQ_ADDR_0, REQ_ADDR_1,
               REQ_WDATA_0, REQ_WDATA_1, RdData, RdData_Valid,
        output GNT_0, GNT_1, RDATA_0, RDATA_1, RDATA_VLD_0, RDATA_VLD_1,
               RD_ERR_0, RD_ERR_1, WrEN, RdEN, Address, WrData
    );

    modport master (
        output REQ_0, REQ_1, REQ_WR_0, REQ_WR_1, REQ_ADDR_0, REQ_ADDR_1,
               REQ_WDATA_0, REQ_WDATA_1, RdData, RdData_Valid,
        input  GNT_0, GNT_1, RDATA_0, RDATA_1, RDATA_VLD_0, RDATA_VLD_1,
               RD_ERR_0, RD_ERR_1, WrEN, RdEN, Address, WrData
    );
endinterface

// File: rtl/rf_access_arbiter.sv
// rf_access_arbiter: two-requester round-robin arbiter for the single
// register-file port. Requester 0 is the UART command controller and
// requester 1 is the secondary configuration master. The arbiter accepts one
// read or write at a time. Reads wait for RdData_Valid, and the read data is
// returned to the requester that owns the transaction.
// Ports:
//   CLK  - clock, rising edge
//   RST  - asynchronous reset, active low
//   bus  - rf_access_arbiter_if.slave (requester handshakes + register-file bus)
// Optional: define RF_ARB_TIMEOUT_EN to abort a read after TIMEOUT_CYC cycles
// in READ. The abort pulses RD_ERR_x and clears RDATA_x. Without the macro a
// read waits indefinitely and RD_ERR_x is tied to 0.
module rf_access_arbiter #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned ADDR_WIDTH  = 4,
    parameter int unsigned TIMEOUT_CYC = 15
) (
    input  logic               CLK,
    input  logic               RST,
    rf_access_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  pri;       // requester favoured on a tie
    logic                  owner;     // requester of the transaction in flight
    logic                  req_any;
    logic                  pick;
    logic                  rd_timeout;
    logic [1:0]            gnt_q;
    logic [1:0]            rvld_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata0_q;
    logic [DATA_WIDTH-1:0] rdata1_q;

    if (TIMEOUT_CYC == 0) begin : g_bad_cfg
        $error("rf_access_arbiter: TIMEOUT_CYC must be nonzero");
    end

    always_comb begin
        req_any = bus.REQ_0 | bus.REQ_1;
        pick    = (bus.REQ_0 && bus.REQ_1) ? pri : bus.REQ_1;
    end

`ifdef RF_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] rd_cnt;
    logic [1:0]       err_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)               rd_cnt <= '0;
        else if (state == READ) rd_cnt <= rd_cnt + CNT_W'(1);
        else                    rd_cnt <= '0;
    end

    // A valid arriving on the timeout edge takes precedence, so it masks the timeout.
    assign rd_timeout = (state == READ) && !bus.RdData_Valid &&
                        (rd_cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            err_q <= '0;
        end else begin
            err_q <= '0;
            if (rd_timeout) err_q[owner] <= 1'b1;
        end
    end

    assign bus.RD_ERR_0 = err_q[0];
    assign bus.RD_ERR_1 = err_q[1];
`else
    assign rd_timeout   = 1'b0;
    assign bus.RD_ERR_0 = 1'b0;
    assign bus.RD_ERR_1 = 1'b0;
`endif

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_any)
                    state_nxt = (pick ? bus.REQ_WR_1 : bus.REQ_WR_0) ? WRITE : READ;
            end
            WRITE: state_nxt = IDLE;
            READ: begin
                if (bus.RdData_Valid || rd_timeout) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Register-file strobes are decoded directly from the state
    always_comb begin
        bus.WrEN = (state == WRITE);
        bus.RdEN = (state == READ);
    end

    // Datapath: request latch, grant/valid pulses, read-data return
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pri      <= 1'b0;
            owner    <= 1'b0;
            gnt_q    <= '0;
            rvld_q   <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            gnt_q  <= '0;
            rvld_q <= '0;
            case (state)
                IDLE: begin
                    if (req_any) begin
                        addr_q      <= pick ? bus.REQ_ADDR_1  : bus.REQ_ADDR_0;
                        wdata_q     <= pick ? bus.REQ_WDATA_1 : bus.REQ_WDATA_0;
                        gnt_q[pick] <= 1'b1;
                        owner       <= pick;
                        pri         <= ~pick;
                    end
                end
                READ: begin
                    if (bus.RdData_Valid) begin
                        if (owner) rdata1_q <= bus.RdData;
                        else       rdata0_q <= bus.RdData;
                        rvld_q[owner] <= 1'b1;
                    end else if (rd_timeout) begin
                        if (owner) rdata1_q <= '0;
                        else       rdata0_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.GNT_0       = gnt_q[0];
    assign bus.GNT_1       = gnt_q[1];
    assign bus.RDATA_VLD_0 = rvld_q[0];
    assign bus.RDATA_VLD_1 = rvld_q[1];
    assign bus.RDATA_0     = rdata0_q;
    assign bus.RDATA_1     = rdata1_q;
    assign bus.Address     = addr_q;
    assign bus.WrData      = wdata_q;

endmodule

// File: doc/rf_access_arbiter.md
Name: rf_access_arbiter

Overview:
- Shares the single register-file port between two requesters: requester 0 is the UART command controller, requester 1 is the secondary configuration master.
- Accepts one read or write request at a time, with round-robin priority.
- Drives the register file's WrEN/RdEN/Address/WrData, waits for RdData_Valid on reads and returns the read data to the owning requester.
- Sits between the command controllers and the register file in the reference clock domain.

Parameters:
- DATA_WIDTH, 8, register file data width.
- ADDR_WIDTH, 4, register file address width.
- TIMEOUT_CYC, 15, read-timeout limit in CLK cycles; used only when RF_ARB_TIMEOUT_EN is defined.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous, active-low reset.
- REQ_0, REQ_1  input  1  request valid, held until GNT_x is seen.
- REQ_WR_0, REQ_WR_1  input  1  request type: 1 = write, 0 = read.
- REQ_ADDR_0, REQ_ADDR_1  input  ADDR_WIDTH  request address.
- REQ_WDATA_0, REQ_WDATA_1  input  DATA_WIDTH  write data.
- GNT_0, GNT_1  output  1  one-cycle request-accepted pulse.
- RDATA_0, RDATA_1  output  DATA_WIDTH  returned read data, held until that requester's next read completes.
- RDATA_VLD_0, RDATA_VLD_1  output  1  one-cycle read-data-valid pulse.
- RD_ERR_0, RD_ERR_1  output  1  one-cycle read-timeout pulse.
- WrEN  output  1  register file write enable.
- RdEN  output  1  register file read enable.
- Address  output  ADDR_WIDTH  register file address.
- WrData  output  DATA_WIDTH  register file write data.
- RdData  input  DATA_WIDTH  register file read data.
- RdData_Valid  input  1  register file read-data valid.

Behaviour:
- Reset:
  - state = IDLE, priority pointer PRI = 0 (requester 0 favoured).
  - All outputs 0: GNT_x, RDATA_x, RDATA_VLD_x, RD_ERR_x, WrEN, RdEN, Address, WrData.
  - Reset asserted mid-transaction aborts it: no GNT, RDATA_VLD or WrEN is produced afterwards.
- States: IDLE, WRITE, READ.
- IDLE:
  - Selection: if both REQ_x are high, pick requester PRI; if only one is high, pick it.
  - On the edge where a request is selected, latch REQ_ADDR into Address and REQ_WDATA into WrData.
  - Same edge: set GNT_sel = 1 for exactly one cycle, set PRI = not sel, go to WRITE if REQ_WR = 1, else READ.
  - No REQ high: stay in IDLE, outputs unchanged.
- WRITE:
  - WrEN = 1, decoded from the state, for exactly one cycle.
  - Next state IDLE.
- READ:
  - RdEN = 1 from the state and held every cycle until RdData_Valid is sampled high.
  - On that edge: RDATA_sel <= RdData, RDATA_VLD_sel = 1 for one cycle, next state IDLE.
- Latency:
  - REQ sampled at edge N gives GNT and WrEN/RdEN high in cycle N+1.
  - Write completes at edge N+1.
  - Read result appears one cycle after the edge where RdData_Valid is sampled.
  - Back-to-back throughput is at most one transaction per 2 cycles; IDLE always lasts at least one cycle between transactions.
- Handshake rules:
  - A requester keeps REQ, REQ_WR, REQ_ADDR and REQ_WDATA stable until GNT.
  - Request fields are ignored after the GNT cycle.
  - REQ high in the GNT cycle is a new request.
  - Requests seen in WRITE or READ are not queued; they are re-evaluated in the next IDLE.
- Ignored inputs: RdData_Valid arriving in IDLE or WRITE is ignored.
- Address and WrData keep their last latched values between transactions.
- The other requester's RDATA is never disturbed by a read.
- RD_ERR_x is constant 0 unless the optional feature is enabled.

Optional Feature:
- RF_ARB_TIMEOUT_EN defined:
  - READ runs a counter from 0.
  - If RdData_Valid has not been seen when the counter reaches TIMEOUT_CYC, on that edge: RdEN drops, RDATA_sel <= 0, RD_ERR_sel = 1 for one cycle, RDATA_VLD_sel stays 0, next state IDLE.
  - RdData_Valid on the same edge as the timeout wins: normal completion, no error.
- RF_ARB_TIMEOUT_EN undefined:
  - No counter; READ waits indefinitely.
  - RD_ERR_x tied to 0.

Test Plan:
- Write then read, requester 0 only: REQ_0 write, addr 0x3, data 0x5A, gives GNT_0 pulse and WrEN for one cycle with Address 0x3, WrData 0x5A. A following read of 0x3, with the model returning 0x5A one cycle after RdEN, gives RDATA_0 = 0x5A and RDATA_VLD_0 pulse.
- Simultaneous requests after reset: REQ_0 write 0x11 and REQ_1 write 0x22 both high; requester 0 is granted first, then requester 1 two cycles later. Two writes with the correct address/data order, PRI ending at 0.
- Fairness: REQ_0 and REQ_1 held high for 8 transactions gives strictly alternating GNT_0/GNT_1 and a grant every 2 cycles.
- Read latency: RdData_Valid delayed 5 cycles gives RdEN held 6 cycles, RDATA_1 = 0xC3 and RDATA_VLD_1 after RdData_Valid; a REQ_0 raised during the wait is granted only after return to IDLE.
- Reset in READ: RST low while RdEN is high gives all outputs 0 immediately; a later RdData_Valid produces no RDATA_VLD.
- With RF_ARB_TIMEOUT_EN, TIMEOUT_CYC = 4, no RdData_Valid: RD_ERR_0 pulses after the timeout, RDATA_0 = 0x00, FSM back in IDLE; a pending REQ_1 is granted next.
